// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit display scan controller. Each digit gets a dark DEAD phase and
// then an ON phase. Per-digit blanking and blinking are applied at the anode decode.
module seg_scan_ctrl #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned DEAD_CYCLES = 16,
   parameter int unsigned BLINK_DIV   = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] blank_mask,
   input  logic [3:0] blink_mask,
   output logic [1:0] sel,
   output logic [3:0] an,
   output logic       frame_tick,
   output logic       blink_phase
);

   localparam int unsigned CntW = $clog2(REFRESH_DIV);
   localparam int unsigned FrmW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYCLES - 1);
   localparam logic [CntW-1:0] OnLast   = CntW'(REFRESH_DIV - 1);
   localparam logic [FrmW-1:0] FrmLast  = FrmW'(BLINK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StDead, StOn} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [1:0]      sel_q;
   logic [FrmW-1:0] frm_q;
   logic            tick_q;
   logic            blink_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sel_q   <= 2'd0;
         frm_q   <= '0;
         tick_q  <= 1'b0;
         blink_q <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (!en) begin
            // Dropping enable parks the scan; sel, frame count and blink phase are kept.
            state_q <= StIdle;
            cnt_q   <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  state_q <= StDead;
                  cnt_q   <= '0;
               end
               StDead: begin
                  if (cnt_q == DeadLast) begin
                     state_q <= StOn;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
               StOn: begin
                  if (cnt_q == OnLast) begin
                     state_q <= StDead;
                     cnt_q   <= '0;
                     sel_q   <= sel_q + 2'd1;
                     if (sel_q == 2'd3) begin
                        tick_q <= 1'b1;
                        if (frm_q == FrmLast) begin
                           frm_q   <= '0;
                           blink_q <= ~blink_q;
                        end else begin
                           frm_q <= frm_q + FrmW'(1);
                        end
                     end
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
               default: begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   // Masks act only on the decode, so a mask change shows up in the same cycle.
   always_comb begin
      an = 4'b1111;
      if (state_q == StOn && !blank_mask[sel_q] && !(blink_mask[sel_q] && blink_q)) begin
         an[sel_q] = 1'b0;
      end
   end

   assign sel         = sel_q;
   assign frame_tick  = tick_q;
   assign blink_phase = blink_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with REFRESH_DIV=4, DEAD_CYCLES=2, BLINK_DIV=2:
// digit period 6 cycles, frame 24 cycles, blink half-period 48 cycles.
module tb_seg_scan_ctrl;

   localparam int unsigned RD = 4;
   localparam int unsigned DC = 2;
   localparam int unsigned BD = 2;
   localparam int DIG   = 6;
   localparam int FRAME = 24;
   localparam int HALF  = 48;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] blank_mask = 4'b0000;
   logic [3:0] blink_mask = 4'b0000;
   logic [1:0] sel;
   logic [3:0] an;
   logic       frame_tick;
   logic       blink_phase;

   int checks = 0;
   int errors = 0;
   int n = 0;  // edges since the last reset edge

   seg_scan_ctrl #(
      .REFRESH_DIV(RD),
      .DEAD_CYCLES(DC),
      .BLINK_DIV  (BD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .blank_mask (blank_mask),
      .blink_mask (blink_mask),
      .sel        (sel),
      .an         (an),
      .frame_tick (frame_tick),
      .blink_phase(blink_phase)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Expected anodes at frame position k (0..23) for a free-running scan.
   function automatic logic [3:0] exp_an(int k, logic bp, logic [3:0] bl, logic [3:0] bk);
      int d = k / DIG;
      logic [3:0] r = 4'b1111;
      if ((k % DIG) >= DC && !bl[d] && !(bk[d] && bp)) r[d] = 1'b0;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      n = 0;
   endtask

   task automatic test_reset();
      en = 1'b1;
      blank_mask = 4'b0000;
      blink_mask = 4'b0000;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({an, sel, frame_tick, blink_phase} !== {4'b1111, 2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got an=%b sel=%b ft=%b bp=%b, expected 1111 00 0 0",
                     an, sel, frame_tick, blink_phase);
         end
      end
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 9; i++) begin
         logic [3:0] e;
         if (i > 0) step();
         e = (n == 0) ? 4'b1111 : exp_an(n - 1, 1'b0, 4'b0, 4'b0);
         checks++;
         if (an !== e) begin
            errors++;
            $display("FAIL reset_release n=%0d: got an=%b, expected %b", n, an, e);
         end
      end
   endtask

   task automatic test_full_scan();
      en = 1'b1;
      blank_mask = 4'b0000;
      blink_mask = 4'b0000;
      do_reset();
      for (int i = 0; i < 2 * FRAME; i++) begin
         int k;
         step();
         k = (n - 1) % FRAME;
         checks++;
         if (an !== exp_an(k, 1'b0, 4'b0, 4'b0) || sel !== 2'(k / DIG) ||
             frame_tick !== (n > 1 && k == 0)) begin
            errors++;
            $display("FAIL full_scan n=%0d: got an=%b sel=%0d ft=%b, expected an=%b sel=%0d ft=%b",
                     n, an, sel, frame_tick, exp_an(k, 1'b0, 4'b0, 4'b0), k / DIG,
                     (n > 1 && k == 0));
         end
      end
   endtask

   task automatic test_blanking();
      en = 1'b1;
      blank_mask = 4'b0100;
      blink_mask = 4'b0000;
      do_reset();
      for (int i = 0; i < FRAME + 2; i++) begin
         int k;
         step();
         k = (n - 1) % FRAME;
         checks++;
         if (an !== exp_an(k, 1'b0, 4'b0100, 4'b0) || frame_tick !== (n > 1 && k == 0)) begin
            errors++;
            $display("FAIL blanking n=%0d: got an=%b ft=%b, expected an=%b ft=%b",
                     n, an, frame_tick, exp_an(k, 1'b0, 4'b0100, 4'b0), (n > 1 && k == 0));
         end
      end
      step();  // n=27: digit 0 ON
      blank_mask = 4'b0001;
      #1;
      checks++;
      if (an !== 4'b1111) begin
         errors++;
         $display("FAIL blank_same_cycle_on: got an=%b, expected 1111", an);
      end
      blank_mask = 4'b0000;
      #1;
      checks++;
      if (an !== 4'b1110) begin
         errors++;
         $display("FAIL blank_same_cycle_off: got an=%b, expected 1110", an);
      end
   endtask

   task automatic test_blink();
      en = 1'b1;
      blank_mask = 4'b0000;
      blink_mask = 4'b0001;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         int k;
         logic bp;
         step();
         k = (n - 1) % FRAME;
         bp = (((n - 1) / HALF) % 2) == 1;
         checks++;
         if (an !== exp_an(k, bp, 4'b0, 4'b0001) || blink_phase !== bp) begin
            errors++;
            $display("FAIL blink n=%0d: got an=%b bp=%b, expected an=%b bp=%b",
                     n, an, blink_phase, exp_an(k, bp, 4'b0, 4'b0001), bp);
         end
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({an, sel, frame_tick, blink_phase} !== {4'b1111, 2'b00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL blink_reset: got an=%b sel=%b ft=%b bp=%b, expected 1111 00 0 0",
                  an, sel, frame_tick, blink_phase);
      end
      blink_mask = 4'b0000;
   endtask

   task automatic test_enable_drop();
      en = 1'b1;
      blank_mask = 4'b0000;
      blink_mask = 4'b0000;
      do_reset();
      repeat (10) step();  // n=10: second ON cycle of digit 1
      checks++;
      if (an !== 4'b1101) begin
         errors++;
         $display("FAIL en_drop_pre: got an=%b, expected 1101", an);
      end
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (an !== 4'b1111 || sel !== 2'd1 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_idle: got an=%b sel=%0d ft=%b, expected 1111 1 0",
                     an, sel, frame_tick);
         end
      end
      en = 1'b1;
      // m counts edges after re-enable; digit 1 restarts with a full DEAD phase.
      for (int m = 1; m <= 19; m++) begin
         logic [3:0] e;
         step();
         e = (m <= 18) ? exp_an(m - 1 + DIG, 1'b0, 4'b0, 4'b0) : 4'b1111;
         checks++;
         if (an !== e || frame_tick !== (m == 19)) begin
            errors++;
            $display("FAIL en_resume m=%0d: got an=%b ft=%b, expected an=%b ft=%b",
                     m, an, frame_tick, e, (m == 19));
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      en = 1'b1;
      blank_mask = 4'b0000;
      blink_mask = 4'b0000;
      do_reset();
      repeat (46) step();  // digit 3 ON of second frame, one tick already counted
      checks++;
      if (an !== 4'b0111 || sel !== 2'd3) begin
         errors++;
         $display("FAIL mid_frame_pre: got an=%b sel=%0d, expected 0111 3", an, sel);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({an, sel, frame_tick, blink_phase} !== {4'b1111, 2'b00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL mid_frame_reset: got an=%b sel=%b ft=%b bp=%b, expected 1111 00 0 0",
                  an, sel, frame_tick, blink_phase);
      end
      n = 0;
      // A cleared frame counter means the first toggle lands 48 edges after restart.
      for (int i = 0; i < 52; i++) begin
         int k;
         logic bp;
         step();
         k = (n - 1) % FRAME;
         bp = (((n - 1) / HALF) % 2) == 1;
         checks++;
         if (blink_phase !== bp || frame_tick !== (n > 1 && k == 0) ||
             an !== exp_an(k, 1'b0, 4'b0, 4'b0)) begin
            errors++;
            $display("FAIL mid_frame_restart n=%0d: got an=%b ft=%b bp=%b, expected %b %b %b",
                     n, an, frame_tick, blink_phase, exp_an(k, 1'b0, 4'b0, 4'b0),
                     (n > 1 && k == 0), bp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_blanking();
      test_blink();
      test_enable_drop();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have one clock, CLK; reset is RST, synchronous and active-high.
REQ-002 Parameter REFRESH_DIV SHALL default to 100000 and set the number of CLK cycles each digit is driven (ON phase); legal range is 2 or more.
REQ-003 Parameter DEAD_CYCLES SHALL default to 16 and set the number of all-anodes-off CLK cycles before each digit (DEAD phase); legal range is 1 to REFRESH_DIV-1.
REQ-004 Parameter BLINK_DIV SHALL default to 32 and set the number of complete 4-digit frames per blink half-period; legal range is 1 or more.
REQ-005 CLK  in  1  system clock; all state updates on its rising edge.
REQ-006 RST  in  1  synchronous active-high reset; has priority over all other inputs.
REQ-007 EN  in  1  scan enable; 1 = run the scan, 0 = idle with display dark.
REQ-008 BLANK_MASK  in  4  bit i = 1 forces digit i dark.
REQ-009 BLINK_MASK  in  4  bit i = 1 makes digit i dark while BLINK_PHASE = 1.
REQ-010 SEL  out  2  digit select, driven to the 4-bit 4-to-1 digit mux select.
REQ-011 AN  out  4  anode enables, active-low; bit i drives digit i.
REQ-012 FRAME_TICK  out  1  one-cycle pulse at the end of each complete frame.
REQ-013 BLINK_PHASE  out  1  current blink phase; 1 = blinking digits dark.

Function
REQ-014 The block SHALL implement a 3-state FSM: IDLE, DEAD, ON.
REQ-015 The block SHALL use a phase counter cnt wide enough for REFRESH_DIV-1, a 2-bit SEL register, and a frame counter wide enough for BLINK_DIV-1.
REQ-016 IDLE transitions: EN=1 moves the FSM to DEAD with cnt=0 and SEL unchanged; EN=0 keeps it in IDLE.
REQ-017 DEAD transitions: cnt increments each cycle; when cnt==DEAD_CYCLES-1 the FSM moves to ON with cnt=0.
REQ-018 ON transitions: cnt increments each cycle; when cnt==REFRESH_DIV-1 the FSM moves to DEAD with cnt=0 and SEL=SEL+1, wrapping 3 to 0.
REQ-019 EN=0 in DEAD or ON SHALL move the FSM to IDLE on the next edge: cnt cleared, SEL held, frame counter and BLINK_PHASE held, and no FRAME_TICK.
REQ-020 The digit period SHALL be DEAD_CYCLES+REFRESH_DIV cycles and the frame period 4*(DEAD_CYCLES+REFRESH_DIV) cycles.
REQ-021 AN SHALL be 4'b1111 in IDLE and DEAD.
REQ-022 In ON, AN[i] SHALL be 0 only if SEL==i, BLANK_MASK[i]==0, and not (BLINK_MASK[i]==1 and BLINK_PHASE==1); all other AN bits are 1.
REQ-023 AN SHALL be a combinational decode of the registered state, SEL and BLINK_PHASE plus the current mask inputs only; a mask change is visible in the same cycle.
REQ-024 At most one AN bit SHALL be low in any cycle.
REQ-025 FRAME_TICK SHALL be registered and high for exactly the first DEAD cycle following the ON phase of SEL=3, i.e. the cycle SEL becomes 0.
REQ-026 On each edge that asserts FRAME_TICK, the frame counter SHALL increment.
REQ-027 When the frame counter is already BLINK_DIV-1 on a FRAME_TICK-asserting edge, it SHALL clear to 0 and BLINK_PHASE SHALL toggle on that same edge.
REQ-028 SEL, FRAME_TICK and BLINK_PHASE SHALL be direct register outputs.
REQ-029 Mask inputs SHALL NOT affect FSM timing, SEL sequencing or FRAME_TICK.

Reset
REQ-030 RST=1 at a rising edge SHALL set state=IDLE, cnt=0, SEL=2'b00, frame counter=0, BLINK_PHASE=0 and FRAME_TICK=0, so AN=4'b1111, regardless of EN or current state.
REQ-031 Reset mid-operation SHALL abort the current digit with no FRAME_TICK.
REQ-032 After reset release with EN=1, the scan SHALL restart with DEAD at SEL=0.

Verification (REFRESH_DIV=4, DEAD_CYCLES=2, BLINK_DIV=2)
REQ-033 Reset test: RST=1 for 3 cycles with EN=1 -> AN=1111, SEL=00, FRAME_TICK=0, BLINK_PHASE=0. After release -> 1 IDLE cycle, then AN=1111 for 2 cycles, then AN=1110 for 4 cycles.
REQ-034 Full scan: EN=1, masks 0 -> AN repeats 1111x2, 1110x4, 1111x2, 1101x4, 1111x2, 1011x4, 1111x2, 0111x4; SEL steps 0,1,2,3; FRAME_TICK has a single 1-cycle pulse every 24 cycles, aligned with SEL returning to 00.
REQ-035 Blanking: BLANK_MASK=0100 -> during SEL=2 ON, AN=1111; other digits are unchanged; FRAME_TICK period stays 24.
REQ-036 Blink: BLINK_MASK=0001 -> BLINK_PHASE toggles on every 2nd FRAME_TICK (48 cycles); digit 0 AN=1110 in phase-0 frames and stays 1111 in phase-1 frames.
REQ-037 Enable drop: EN=0 at ON cycle 2 of SEL=1 -> next cycle AN=1111, state IDLE, SEL=01 held. EN=1 again -> 1 IDLE cycle, 2 DEAD cycles, then AN=1101 for a full 4 cycles.
REQ-038 Reset mid-frame: RST=1 during ON of SEL=3 with frame counter=1 -> next cycle SEL=00, BLINK_PHASE=0, frame counter=0, FRAME_TICK=0, AN=1111.
